// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_sequencer
// Description : Fetch/decode/execute control sequencer for the 16-bit
//               accumulator CPU. Consumes the opcode field of the instruction
//               register and drives every PC, IR, ACC, carry and memory strobe
//               in the datapath. One FSM step per clk edge while ce=1.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: CTRL_HALT_RESUME_EN
//   defined   -> adds input 'run'; run=1 with ce=1 in HALT resumes at FETCH
//   undefined -> HALT is left only through rst
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset (state -> INIT)
//   ce           in   clock enable; strobes valid and state advances only when 1
//   code_op[2:0] in   opcode from instruction register bits 15:13
//   carry        in   current carry flag
//   run          in   (CTRL_HALT_RESUME_EN only) resume from HALT
//   init_PC      out  synchronous PC clear
//   load_PC      out  PC load strobe
//   sel_PC_src   out  PC source: 0 = PC+1, 1 = instruction address field
//   sel_adr      out  memory address: 0 = PC, 1 = instruction address field
//   load_RI      out  instruction register load strobe
//   load_ACC     out  accumulator load strobe
//   ual_op[1:0]  out  ALU op: 00 NOR, 01 ADD, 10 PASS(M), 11 AND
//   load_carry   out  carry flag update from ALU
//   clear_carry  out  carry flag synchronous clear
//   mem_ce       out  memory access enable
//   mem_we       out  memory write enable
//   halted       out  high while in HALT
//   state        out  current state (debug)
// ============================================================================
module ctrl_sequencer #(
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [2:0]         code_op,
  input  logic               carry,
`ifdef CTRL_HALT_RESUME_EN
  input  logic               run,
`endif
  output logic               init_PC,
  output logic               load_PC,
  output logic               sel_PC_src,
  output logic               sel_adr,
  output logic               load_RI,
  output logic               load_ACC,
  output logic [1:0]         ual_op,
  output logic               load_carry,
  output logic               clear_carry,
  output logic               mem_ce,
  output logic               mem_we,
  output logic               halted,
  output logic [STATE_W-1:0] state
);

  // Encoding is externally visible through 'state'; values are fixed.
  typedef enum logic [STATE_W-1:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_STORE  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] c_OP_NOR = 3'b000;
  localparam logic [2:0] c_OP_ADD = 3'b001;
  localparam logic [2:0] c_OP_STA = 3'b010;
  localparam logic [2:0] c_OP_JCC = 3'b011;
  localparam logic [2:0] c_OP_LDA = 3'b100;
  localparam logic [2:0] c_OP_AND = 3'b101;
  localparam logic [2:0] c_OP_JMP = 3'b110;
  localparam logic [2:0] c_OP_HLT = 3'b111;

  state_t     r_state;
  state_t     w_next;

  logic       w_init_pc;
  logic       w_load_pc;
  logic       w_sel_pc_src;
  logic       w_sel_adr;
  logic       w_load_ri;
  logic       w_load_acc;
  logic [1:0] w_ual_op;
  logic       w_load_carry;
  logic       w_clear_carry;
  logic       w_mem_ce;
  logic       w_mem_we;
  logic       w_halted;

  // State register: asynchronous reset, advances only on enabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_INIT;
    end else if (ce) begin
      r_state <= w_next;
    end
  end

  // Next-state and ungated output decode.
  always_comb begin
    w_next        = r_state;
    w_init_pc     = 1'b0;
    w_load_pc     = 1'b0;
    w_sel_pc_src  = 1'b0;
    w_sel_adr     = 1'b0;
    w_load_ri     = 1'b0;
    w_load_acc    = 1'b0;
    w_ual_op      = 2'b00;
    w_load_carry  = 1'b0;
    w_clear_carry = 1'b0;
    w_mem_ce      = 1'b0;
    w_mem_we      = 1'b0;
    w_halted      = 1'b0;

    case (r_state)
      S_INIT: begin
        w_init_pc = 1'b1;
        w_next    = S_FETCH;
      end

      // IR capture and PC+1 happen on the same edge.
      S_FETCH: begin
        w_mem_ce  = 1'b1;
        w_load_ri = 1'b1;
        w_load_pc = 1'b1;
        w_next    = S_DECODE;
      end

      // Mealy decode: jumps complete here, so they cost only two cycles.
      S_DECODE: begin
        case (code_op)
          c_OP_NOR, c_OP_ADD, c_OP_LDA, c_OP_AND: w_next = S_EXEC;
          c_OP_STA: w_next = S_STORE;
          c_OP_JCC: begin
            // Jump on carry clear; a set carry is consumed instead.
            if (!carry) begin
              w_load_pc    = 1'b1;
              w_sel_pc_src = 1'b1;
            end else begin
              w_clear_carry = 1'b1;
            end
            w_next = S_FETCH;
          end
          c_OP_JMP: begin
            w_load_pc    = 1'b1;
            w_sel_pc_src = 1'b1;
            w_next       = S_FETCH;
          end
          c_OP_HLT: w_next = S_HALT;
          default:  w_next = S_INIT;
        endcase
      end

      // code_op is still valid here because the IR only loads in FETCH.
      S_EXEC: begin
        w_sel_adr  = 1'b1;
        w_mem_ce   = 1'b1;
        w_load_acc = 1'b1;
        case (code_op)
          c_OP_ADD: begin
            w_ual_op     = 2'b01;
            w_load_carry = 1'b1;
          end
          c_OP_LDA: w_ual_op = 2'b10;
          c_OP_AND: w_ual_op = 2'b11;
          default:  w_ual_op = 2'b00;
        endcase
        w_next = S_FETCH;
      end

      S_STORE: begin
        w_sel_adr = 1'b1;
        w_mem_ce  = 1'b1;
        w_mem_we  = 1'b1;
        w_next    = S_FETCH;
      end

      S_HALT: begin
        w_halted = 1'b1;
`ifdef CTRL_HALT_RESUME_EN
        if (run) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_HALT;
        end
`else
        w_next = S_HALT;
`endif
      end

      // Unused codes recover to INIT with every output quiet.
      default: w_next = S_INIT;
    endcase
  end

  // Strobes are qualified by ce; selects, ual_op, halted and state are not.
  assign init_PC     = w_init_pc     & ce;
  assign load_PC     = w_load_pc     & ce;
  assign load_RI     = w_load_ri     & ce;
  assign load_ACC    = w_load_acc    & ce;
  assign load_carry  = w_load_carry  & ce;
  assign clear_carry = w_clear_carry & ce;
  assign mem_ce      = w_mem_ce      & ce;
  assign mem_we      = w_mem_we      & ce;
  assign sel_PC_src  = w_sel_pc_src;
  assign sel_adr     = w_sel_adr;
  assign ual_op      = w_ual_op;
  assign halted      = w_halted;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_sequencer
// Description : Self-checking bench for ctrl_sequencer. A behavioural model of
//               the instruction cycle predicts every output each cycle; directed
//               vectors add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// Macro       : CTRL_HALT_RESUME_EN (matches the DUT build)
// ============================================================================
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [2:0] code_op;
  logic       carry;
  logic       run;
  logic       init_PC, load_PC, sel_PC_src, sel_adr, load_RI, load_ACC;
  logic [1:0] ual_op;
  logic       load_carry, clear_carry, mem_ce, mem_we, halted;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  bit tb_done = 1'b0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.STATE_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .code_op     (code_op),
    .carry       (carry),
`ifdef CTRL_HALT_RESUME_EN
    .run         (run),
`endif
    .init_PC     (init_PC),
    .load_PC     (load_PC),
    .sel_PC_src  (sel_PC_src),
    .sel_adr     (sel_adr),
    .load_RI     (load_RI),
    .load_ACC    (load_ACC),
    .ual_op      (ual_op),
    .load_carry  (load_carry),
    .clear_carry (clear_carry),
    .mem_ce      (mem_ce),
    .mem_we      (mem_we),
    .halted      (halted),
    .state       (state)
  );

  // --------------------------------------------------------------------------
  // Behavioural model: tracks which step of the instruction cycle the CPU is
  // in and derives outputs from the instruction class.
  // Steps: 0 init, 1 fetch, 2 decode, 3 execute, 4 store, 5 halt.
  // --------------------------------------------------------------------------
  int m_step;

  function automatic bit is_alu(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd5);
  endfunction

  function automatic logic [1:0] alu_code(input logic [2:0] op);
    logic [1:0] tbl [8];
    tbl = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0};
    return tbl[op];
  endfunction

  function automatic int model_next(input int st, input logic [2:0] op,
                                    input logic c, input logic rn);
    int nx;
    nx = st;
    if (st == 0 || st == 3 || st == 4) nx = 1;
    else if (st == 1) nx = 2;
    else if (st == 2) begin
      if (is_alu(op))       nx = 3;
      else if (op == 3'd2)  nx = 4;
      else if (op == 3'd7)  nx = 5;
      else                  nx = 1;
    end else if (st == 5) begin
`ifdef CTRL_HALT_RESUME_EN
      nx = rn ? 1 : 5;
`else
      nx = 5;
`endif
    end
    if (c === 1'bx) nx = st;
    return nx;
  endfunction

  // Packed order: init_PC load_PC sel_PC_src sel_adr load_RI load_ACC
  //               ual_op[1:0] load_carry clear_carry mem_ce mem_we halted
  function automatic logic [12:0] model_out(input int st, input logic [2:0] op,
                                            input logic c, input logic en);
    logic ip, lp, sps, sa, lri, lacc, lc, cc, mce, mwe, hl;
    logic [1:0] u;
    {ip, lp, sps, sa, lri, lacc, lc, cc, mce, mwe, hl} = '0;
    u = 2'd0;
    if (st == 0) ip = 1'b1;
    if (st == 1) begin mce = 1'b1; lri = 1'b1; lp = 1'b1; end
    if (st == 2 && (op == 3'd6 || (op == 3'd3 && !c))) begin lp = 1'b1; sps = 1'b1; end
    if (st == 2 && op == 3'd3 && c) cc = 1'b1;
    if (st == 3) begin
      sa = 1'b1; mce = 1'b1; lacc = 1'b1;
      u = alu_code(op); lc = (op == 3'd1);
    end
    if (st == 4) begin sa = 1'b1; mce = 1'b1; mwe = 1'b1; end
    if (st == 5) hl = 1'b1;
    if (!en) {ip, lp, lri, lacc, lc, cc, mce, mwe} = '0;
    return {ip, lp, sps, sa, lri, lacc, u, lc, cc, mce, mwe, hl};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_step <= 0;
    else if (ce) m_step <= model_next(m_step, code_op, carry, run);
  end

  wire [12:0] dut_vec = {init_PC, load_PC, sel_PC_src, sel_adr, load_RI, load_ACC,
                         ual_op, load_carry, clear_carry, mem_ce, mem_we, halted};
  wire [7:0]  strobes = {init_PC, load_PC, load_RI, load_ACC,
                         load_carry, clear_carry, mem_ce, mem_we};

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!tb_done) begin
      n_tests++;
      if (dut_vec !== model_out(m_step, code_op, carry, ce) || state !== 3'(m_step)) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: outputs=%b state=%0d, expected outputs=%b state=%0d",
                 $time, dut_vec, state, model_out(m_step, code_op, carry, ce), m_step);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops [3];
    rst = 1'b1; ce = 1'b0; code_op = 3'd0; carry = 1'b0; run = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset_state", 32'(state), 0);
    chk("reset_init_pc_ce0", 32'(init_PC), 0);

    // Release reset, enable: cycle 0 is INIT, cycle 1 is FETCH.
    rst = 1'b0; ce = 1'b1; #1;
    chk("init_state", 32'(state), 0);
    chk("init_init_pc", 32'(init_PC), 1);
    chk("init_halted", 32'(halted), 0);
    tick();
    chk("fetch_state", 32'(state), 1);
    chk("fetch_strobes", 32'({mem_ce, load_RI, load_PC, sel_adr, sel_PC_src}), 32'b11100);

    // ADD
    code_op = 3'd1;
    tick();
    chk("add_decode_state", 32'(state), 2);
    chk("add_decode_strobes", 32'(strobes), 0);
    tick();
    chk("add_exec_state", 32'(state), 3);
    chk("add_exec_outs", 32'({load_ACC, load_carry, ual_op, sel_adr, mem_we}), 32'b110110);
    tick();
    chk("add_back_fetch", 32'(state), 1);

    // JCC, carry clear: jump taken
    code_op = 3'd3; carry = 1'b0;
    tick();
    chk("jcc_c0_outs", 32'({load_PC, sel_PC_src, clear_carry}), 32'b110);
    tick();
    chk("jcc_c0_fetch", 32'(state), 1);

    // JCC, carry set: carry cleared, no jump
    carry = 1'b1;
    tick();
    chk("jcc_c1_outs", 32'({load_PC, clear_carry}), 32'b01);
    tick();
    chk("jcc_c1_fetch", 32'(state), 1);
    carry = 1'b0;

    // STA: FETCH -> DECODE -> STORE -> FETCH
    code_op = 3'd2;
    tick();
    tick();
    chk("sta_store_state", 32'(state), 4);
    chk("sta_store_outs", 32'({mem_we, mem_ce, sel_adr, load_ACC}), 32'b1110);
    tick();
    chk("sta_3cyc_fetch", 32'(state), 1);

    // AND with ce held low for three cycles in EXEC
    code_op = 3'd5;
    tick();
    tick();
    chk("and_exec_state", 32'(state), 3);
    @(negedge clk);
    ce = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ce0_hold_state", 32'(state), 3);
      chk("ce0_strobes", 32'(strobes), 0);
      chk("ce0_ual_kept", 32'(ual_op), 3);
    end
    @(negedge clk);
    ce = 1'b1; #1;
    chk("ce1_load_acc", 32'(load_ACC), 1);
    tick();
    chk("ce1_load_acc_once", 32'(load_ACC), 0);
    chk("ce1_fetch", 32'(state), 1);

    // NOR, LDA, JMP: checked by the model; bounded return to FETCH
    ops = '{3'd0, 3'd4, 3'd6};
    for (int j = 0; j < 3; j++) begin
      int k;
      code_op = ops[j];
      k = 0;
      do begin
        tick();
        k++;
      end while (state != 3'd1 && k < 5);
      chk("op_return_fetch", 32'(state), 1);
    end

    // Reset asserted during STORE
    code_op = 3'd2;
    tick();
    tick();
    @(negedge clk);
    chk("pre_rst_mem_we", 32'(mem_we), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_store_we", 32'(mem_we), 0);
    chk("rst_mid_store_state", 32'(state), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_fetch", 32'(state), 1);

    // HLT
    code_op = 3'd7;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", 32'(state), 5);
      chk("halt_flag", 32'(halted), 1);
      tick();
    end
    run = 1'b1;
    tick();
`ifdef CTRL_HALT_RESUME_EN
    chk("halt_resume", 32'(state), 1);
`else
    chk("halt_no_resume", 32'(state), 5);
`endif
    run = 1'b0;
    @(negedge clk);
    #1;
    tb_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Control-unit sequencer for the 16-bit-instruction accumulator CPU. It sits directly downstream of the instruction register and consumes its 3-bit opcode field. It drives every load, select and memory strobe in the datapath: PC, instruction register, accumulator, carry flag and the shared memory. It runs a fetch/decode/execute state machine, one step per cycle while ce=1.

Parameters:
STATE_W, 3, width of state register and debug state output (fixed encoding below; not to be reduced)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ce  in  1  clock enable; state advances and strobes are valid only when 1
code_op  in  3  opcode from instruction register (bits 15:13)
carry  in  1  current carry flag from datapath
init_PC  out  1  synchronous clear of PC
load_PC  out  1  PC load strobe
sel_PC_src  out  1  PC source: 0 = PC+1, 1 = instruction address field
sel_adr  out  1  memory address mux: 0 = PC, 1 = instruction address field
load_RI  out  1  instruction register load strobe
load_ACC  out  1  accumulator load strobe
ual_op  out  2  ALU op: 00 NOR, 01 ADD, 10 PASS(M), 11 AND
load_carry  out  1  carry flag update from ALU
clear_carry  out  1  carry flag synchronous clear
mem_ce  out  1  memory access enable (asynchronous-read memory)
mem_we  out  1  memory write enable
halted  out  1  high while in HALT
state  out  STATE_W  current state, for debug/verification

Behaviour:
- Reset: rst=1 forces state=INIT asynchronously. While in INIT, init_PC=ce and all other outputs are 0 (ual_op=00, halted=0).
- State encoding:
  - INIT=0, FETCH=1, DECODE=2, EXEC=3, STORE=4, HALT=5.
  - Codes 6 and 7 are illegal and go to INIT on the next ce cycle, with all outputs 0.
- State register updates only on a clk edge with ce=1. With ce=0, state holds and every strobe output is forced to 0. Strobes are init_PC, load_PC, load_RI, load_ACC, load_carry, clear_carry, mem_ce and mem_we. Selects and ual_op keep their decoded values. halted and state are not gated by ce.
- INIT: init_PC=1; next state is FETCH.
- FETCH: sel_adr=0, mem_ce=1, load_RI=1, load_PC=1, sel_PC_src=0; next state is DECODE. The instruction register and PC+1 are captured on the same edge.
- DECODE outputs are a Mealy function of code_op and carry:
  - 000 NOR, 001 ADD, 100 LDA, 101 AND: no strobes; next state is EXEC.
  - 010 STA: no strobes; next state is STORE.
  - 011 JCC, carry=0: load_PC=1, sel_PC_src=1; next state is FETCH.
  - 011 JCC, carry=1: clear_carry=1, no jump; next state is FETCH.
  - 110 JMP: load_PC=1, sel_PC_src=1; next state is FETCH.
  - 111 HLT: next state is HALT.
- EXEC: sel_adr=1, mem_ce=1, load_ACC=1; next state is FETCH.
  - ual_op from opcode: NOR 00, ADD 01, LDA 10, AND 11.
  - load_carry=1 only for ADD.
  - code_op must stay stable, because the instruction register is not loaded outside FETCH.
- STORE: sel_adr=1, mem_ce=1, mem_we=1; next state is FETCH.
- HALT: halted=1, no strobes; remains in HALT until rst.
- Instruction cycle counts:
  - JCC, JMP and HLT entry: 2 cycles (FETCH, DECODE).
  - ALU ops and STA: 3 cycles.
  - All counts are in ce=1 cycles.
- At most one of load_ACC, mem_we and load_PC-with-sel_PC_src=1 is asserted in any cycle. load_PC in FETCH and load_RI always coincide.
- Reset asserted mid-instruction returns to INIT immediately; no partial write completes after rst rises.

Optional Feature:
- Macro: CTRL_HALT_RESUME_EN.
- Defined: adds input port run (1 bit). In HALT, with ce=1 and run=1, next state is FETCH, so execution resumes at the current PC (the address after the HLT). run is ignored in all other states.
- Undefined: no run port; HALT is left only via rst.

Test Plan:
- Reset then ce=1 for 2 cycles -> cycle 0: state=0, init_PC=1; cycle 1: state=1, mem_ce=1, load_RI=1, load_PC=1, sel_adr=0.
- code_op=001 (ADD) at DECODE -> next cycle EXEC: load_ACC=1, load_carry=1, ual_op=01, sel_adr=1; then state=1 (FETCH).
- code_op=011 with carry=0 -> DECODE: load_PC=1, sel_PC_src=1, clear_carry=0. Repeat with carry=1 -> clear_carry=1, load_PC=0. Both then go to FETCH.
- code_op=010 (STA) -> STORE cycle: mem_we=1, mem_ce=1, sel_adr=1, load_ACC=0; 3 cycles total from FETCH to next FETCH.
- Toggle ce=0 for 3 cycles in EXEC -> state stays 3, all strobes 0. With ce=1 -> load_ACC=1 for exactly one cycle.
- code_op=111 -> halted=1, state=5 held for 10 cycles. Assert rst mid-STORE -> mem_we drops immediately, state=0. With CTRL_HALT_RESUME_EN, run=1 in HALT -> state=1 on the next edge.
